fetch_pc_sequencer: RTL and testbench

Generates the fetch PC stream for the 3-stage front end and issues line-aligned fetch addresses to the icache over a valid/ready handshake. Arbitrates the three redirect sources: external PC redirect, back-end mispredict resolve, and pre-decode taken presolve. Tracks in-flight icache requests with an epoch tag so that responses made stale by a flush are dropped. It sits ahead of stage 1, alongside the front-end stall/flush logic, and consumes its hold signal.

---
 rtl/fetch_pc_sequencer_pkg.sv | 40 ++++
 rtl/fetch_tag_fifo.sv | 55 +++++
 rtl/fetch_pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared front-end package for the fetch PC sequencer.
// Holds the default geometry constants, the sequencer state enum, the
// in-flight fetch tag {pc, epoch} and the redirect-source priority encoder.
package fetch_pc_sequencer_pkg;

  localparam int FE_ADDR_W          = 64;
  localparam int FE_FETCH_BYTES     = 16;
  localparam int FE_MAX_OUTSTANDING = 2;
  // One extra bit over the in-flight depth so a stale tag never aliases.
  localparam int FE_EPOCH_W         = $clog2(FE_MAX_OUTSTANDING) + 1;
  localparam logic [FE_ADDR_W-1:0] FE_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FE_ADDR_W-1:0]  pc;
    logic [FE_EPOCH_W-1:0] epoch;
  } fetch_tag_t;

  typedef enum logic [1:0] {
    REDIR_NONE     = 2'd0,
    REDIR_EXT      = 2'd1,
    REDIR_RESOLVE  = 2'd2,
    REDIR_PRESOLVE = 2'd3
  } redir_src_e;

  // Fixed priority: external > back-end mispredict > pre-decode taken.
  function automatic redir_src_e redir_pick(input logic ext, input logic res,
                                            input logic pre);
    if (ext)      return REDIR_EXT;
    else if (res) return REDIR_RESOLVE;
    else if (pre) return REDIR_PRESOLVE;
    return REDIR_NONE;
  endfunction

endpackage

// File: rtl/fetch_tag_fifo.sv
// In-order tag FIFO for accepted-but-unanswered icache requests.
// Ports: clock, reset (async active-low), push/push_data, pop,
//        head (combinational view of the oldest entry), count (occupancy).
// A pop against an empty FIFO is ignored; the caller never pushes when full.
module fetch_tag_fifo
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int  DEPTH = FE_MAX_OUTSTANDING,
  parameter type T     = fetch_tag_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop & (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: produces the line-aligned fetch address stream for the
// 3-stage front end, arbitrates redirects, and epoch-tags in-flight icache
// requests so responses made stale by a redirect are dropped.
// Ports:
//   clock, reset (async active-low)
//   io_i_pc_redirect_*        external redirect (highest priority)
//   io_i_branch_resolve_*     back-end resolve; redirects on mispred
//   io_i_branch_presolve_*    pre-decode prediction; redirects on taken
//   io_i_fetch_hold           downstream hold, suppresses new requests
//   io_o_icache_addr_valid/io_o_icache_addr/io_i_icache_addr_ready  request
//   io_i_icache_data_valid    in-order icache response strobe
//   io_o_resp_valid/io_o_resp_pc  response is live-epoch, with its aligned PC
//   io_o_outstanding          in-flight request count
// Optional: define FETCH_SEQ_PERF_EN to add saturating 32-bit counters
//   io_o_perf_redirects (winning redirects) and io_o_perf_dropped (stale drops).
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W          = FE_ADDR_W,
  parameter int                FETCH_BYTES     = FE_FETCH_BYTES,
  parameter int                MAX_OUTSTANDING = FE_MAX_OUTSTANDING,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(FE_RESET_PC)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             io_i_pc_redirect_valid,
  input  logic [ADDR_W-1:0]                io_i_pc_redirect_target,
  input  logic                             io_i_branch_resolve_valid,
  input  logic                             io_i_branch_resolve_mispred,
  input  logic [ADDR_W-1:0]                io_i_branch_resolve_target,
  input  logic                             io_i_branch_presolve_valid,
  input  logic                             io_i_branch_presolve_taken,
  input  logic [ADDR_W-1:0]                io_i_branch_presolve_target,
  input  logic                             io_i_fetch_hold,
  output logic                             io_o_icache_addr_valid,
  output logic [ADDR_W-1:0]                io_o_icache_addr,
  input  logic                             io_i_icache_addr_ready,
  input  logic                             io_i_icache_data_valid,
  output logic                             io_o_resp_valid,
  output logic [ADDR_W-1:0]                io_o_resp_pc,
  output logic [$clog2(MAX_OUTSTANDING):0] io_o_outstanding
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]                      io_o_perf_redirects,
  output logic [31:0]                      io_o_perf_dropped
`endif
);

  localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int EPOCH_W = CNT_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(FETCH_BYTES - 1);

  // Local tag layout follows this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [EPOCH_W-1:0] epoch;
  } tag_t;

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pc;
  logic [EPOCH_W-1:0] epoch;
  logic [CNT_W-1:0]   count;
  tag_t               head;
  tag_t               push_tag;
  redir_src_e         redir_src;
  logic               redir;
  logic [ADDR_W-1:0]  redir_tgt;
  logic               accept;
  logic               pop;
  logic               resp_live;

  always_comb begin
    redir_src = redir_pick(io_i_pc_redirect_valid,
                           io_i_branch_resolve_valid & io_i_branch_resolve_mispred,
                           io_i_branch_presolve_valid & io_i_branch_presolve_taken);
  end

  always_comb begin
    redir_tgt = '0;
    case (redir_src)
      REDIR_EXT:      redir_tgt = io_i_pc_redirect_target;
      REDIR_RESOLVE:  redir_tgt = io_i_branch_resolve_target;
      REDIR_PRESOLVE: redir_tgt = io_i_branch_presolve_target;
      default:        redir_tgt = '0;
    endcase
  end

  assign redir  = (redir_src != REDIR_NONE);

  assign io_o_icache_addr_valid = (state == ST_FETCH) & ~io_i_fetch_hold &
                                  (count < CNT_W'(MAX_OUTSTANDING));
  // Address reads 0 while booting so every output is quiet out of reset.
  assign io_o_icache_addr = (state == ST_BOOT) ? '0 : pc;

  assign accept = io_o_icache_addr_valid & io_i_icache_addr_ready;
  // A strobe with nothing in flight is spurious and must not pop.
  assign pop    = io_i_icache_data_valid & (count != '0);

  // Accepted request carries the pre-redirect epoch, so a same-cycle
  // redirect automatically marks it stale.
  assign push_tag = '{pc: pc, epoch: epoch};

  assign resp_live        = pop & (head.epoch == epoch) & ~redir;
  assign io_o_resp_valid  = resp_live;
  assign io_o_resp_pc     = head.pc;
  assign io_o_outstanding = count;

  fetch_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (tag_t)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (push_tag),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_BOOT;
      pc    <= RESET_PC & ~OFF_MASK;
      epoch <= '0;
    end else begin
      if (redir) begin
        pc    <= redir_tgt & ~OFF_MASK;
        epoch <= epoch + EPOCH_W'(1);
      end else if (accept) begin
        pc <= pc + ADDR_W'(FETCH_BYTES);
      end

      case (state)
        ST_BOOT:  state <= ST_FETCH;
        ST_FETCH: if (accept && !pop && count == CNT_W'(MAX_OUTSTANDING - 1))
                    state <= ST_FULL;
        // Redirects while FULL only move pc/epoch; leave on returned credit.
        ST_FULL:  if (pop && !accept) state <= ST_FETCH;
        default:  state <= ST_BOOT;
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic stale_drop;
  assign stale_drop = pop & ~resp_live;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_o_perf_redirects <= '0;
      io_o_perf_dropped   <= '0;
    end else begin
      if (redir && io_o_perf_redirects != '1)
        io_o_perf_redirects <= io_o_perf_redirects + 32'd1;
      if (stale_drop && io_o_perf_dropped != '1)
        io_o_perf_dropped <= io_o_perf_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed self-checking bench for fetch_pc_sequencer (default parameters).
// Tasks run back to back and share DUT state; each task starts just after a
// rising edge, drives inputs, samples on the falling edge, then advances.
module tb_fetch_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pc_redir_v = 1'b0;
  logic [63:0] pc_redir_t = '0;
  logic        res_v = 1'b0;
  logic        res_m = 1'b0;
  logic [63:0] res_t = '0;
  logic        pre_v = 1'b0;
  logic        pre_tk = 1'b0;
  logic [63:0] pre_t = '0;
  logic        hold = 1'b0;
  logic        addr_valid;
  logic [63:0] addr;
  logic        ready = 1'b0;
  logic        data_valid = 1'b0;
  logic        resp_valid;
  logic [63:0] resp_pc;
  logic [1:0]  outstanding;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_dropped;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  fetch_pc_sequencer dut (
    .clock                       (clock),
    .reset                       (reset),
    .io_i_pc_redirect_valid      (pc_redir_v),
    .io_i_pc_redirect_target     (pc_redir_t),
    .io_i_branch_resolve_valid   (res_v),
    .io_i_branch_resolve_mispred (res_m),
    .io_i_branch_resolve_target  (res_t),
    .io_i_branch_presolve_valid  (pre_v),
    .io_i_branch_presolve_taken  (pre_tk),
    .io_i_branch_presolve_target (pre_t),
    .io_i_fetch_hold             (hold),
    .io_o_icache_addr_valid      (addr_valid),
    .io_o_icache_addr            (addr),
    .io_i_icache_addr_ready      (ready),
    .io_i_icache_data_valid      (data_valid),
    .io_o_resp_valid             (resp_valid),
    .io_o_resp_pc                (resp_pc),
    .io_o_outstanding            (outstanding)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .io_o_perf_redirects         (perf_redirects),
    .io_o_perf_dropped           (perf_dropped)
`endif
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick();
    sample();
    n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", addr_valid); end
    n_run++; if (addr !== 64'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", addr); end
    n_run++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid); end
    n_run++; if (resp_pc !== 64'h0) begin n_fail++; $display("FAIL rst_resp_pc got=%h exp=0", resp_pc); end
    tick();
    reset = 1'b1;
    ready = 1'b1;
    sample();
    n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got=%0b exp=0", addr_valid); end
    tick();
  endtask

  task automatic test_seq_fetch;
    sample();
    n_run++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL seq0_valid got=%0b exp=1", addr_valid); end
    n_run++; if (addr !== 64'h8000_0000) begin n_fail++; $display("FAIL seq0_addr got=%h exp=80000000", addr); end
    tick();
    sample();
    n_run++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL seq1_valid got=%0b exp=1", addr_valid); end
    n_run++; if (addr !== 64'h8000_0010) begin n_fail++; $display("FAIL seq1_addr got=%h exp=80000010", addr); end
    n_run++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL seq1_outstanding got=%0d exp=1", outstanding); end
    tick();
    sample();
    n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid got=%0b exp=0", addr_valid); end
    n_run++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL full_outstanding got=%0d exp=2", outstanding); end
    tick();
  endtask

  task automatic test_back_to_back;
    data_valid = 1'b1;
    sample();
    n_run++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_resp0_valid got=%0b exp=1", resp_valid); end
    n_run++; if (resp_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL b2b_resp0_pc got=%h exp=80000000", resp_pc); end
    tick();
    sample();
    n_run++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%0b exp=1", addr_valid); end
    n_run++; if (addr !== 64'h8000_0020) begin n_fail++; $display("FAIL b2b_addr got=%h exp=80000020", addr); end
    n_run++; if (resp_pc !== 64'h8000_0010) begin n_fail++; $display("FAIL b2b_resp1_pc got=%h exp=80000010", resp_pc); end
    tick();
    data_valid = 1'b0;
    sample();
    n_run++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL b2b_outstanding got=%0d exp=1", outstanding); end
    n_run++; if (addr !== 64'h8000_0030) begin n_fail++; $display("FAIL b2b_next_addr got=%h exp=80000030", addr); end
    n_run++; if (resp_pc !== 64'h8000_0020) begin n_fail++; $display("FAIL b2b_head_pc got=%h exp=80000020", resp_pc); end
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_resp got=%0b exp=0", resp_valid); end
  endtask

  task automatic test_hold;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL hold%0d_valid got=%0b exp=0", i, addr_valid); end
      n_run++; if (addr !== 64'h8000_0030) begin n_fail++; $display("FAIL hold%0d_addr got=%h exp=80000030", i, addr); end
      tick();
    end
    hold = 1'b0;
    sample();
    n_run++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL unhold_valid got=%0b exp=1", addr_valid); end
    n_run++; if (addr !== 64'h8000_0030) begin n_fail++; $display("FAIL unhold_addr got=%h exp=80000030", addr); end
    tick();
  endtask

  task automatic test_mispredict;
    res_v = 1'b1; res_m = 1'b1; res_t = 64'h8000_1234;
    tick();
    res_v = 1'b0; res_m = 1'b0;
    ready = 1'b0;
    data_valid = 1'b1;
    sample();
    n_run++; if (addr !== 64'h8000_1230) begin n_fail++; $display("FAIL mp_addr got=%h exp=80001230", addr); end
    n_run++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL mp_outstanding got=%0d exp=2", outstanding); end
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mp_stale0 got=%0b exp=0", resp_valid); end
    tick();
    sample();
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mp_stale1 got=%0b exp=0", resp_valid); end
    n_run++; if (resp_pc !== 64'h8000_0030) begin n_fail++; $display("FAIL mp_stale1_pc got=%h exp=80000030", resp_pc); end
    tick();
    data_valid = 1'b0;
    ready = 1'b1;
    sample();
    n_run++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL mp_new_valid got=%0b exp=1", addr_valid); end
    n_run++; if (addr !== 64'h8000_1230) begin n_fail++; $display("FAIL mp_new_addr got=%h exp=80001230", addr); end
    tick();
    ready = 1'b0;
    data_valid = 1'b1;
    sample();
    n_run++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL mp_live_valid got=%0b exp=1", resp_valid); end
    n_run++; if (resp_pc !== 64'h8000_1230) begin n_fail++; $display("FAIL mp_live_pc got=%h exp=80001230", resp_pc); end
    tick();
    data_valid = 1'b0;
  endtask

  task automatic test_priority;
    pc_redir_v = 1'b1; pc_redir_t = 64'h100;
    res_v = 1'b1; res_m = 1'b1; res_t = 64'h200;
    pre_v = 1'b1; pre_tk = 1'b1; pre_t = 64'h300;
    tick();
    pc_redir_v = 1'b0; res_v = 1'b0; res_m = 1'b0; pre_v = 1'b0; pre_tk = 1'b0;
    sample();
    n_run++; if (addr !== 64'h100) begin n_fail++; $display("FAIL prio_all_addr got=%h exp=100", addr); end
    n_run++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL prio_all_valid got=%0b exp=1", addr_valid); end
    res_v = 1'b1; res_t = 64'h777;
    pre_v = 1'b1; pre_t = 64'h888;
    tick();
    res_v = 1'b0; pre_v = 1'b0;
    sample();
    n_run++; if (addr !== 64'h100) begin n_fail++; $display("FAIL prio_noredir_addr got=%h exp=100", addr); end
    res_v = 1'b1; res_m = 1'b1; res_t = 64'h205;
    pre_v = 1'b1; pre_tk = 1'b1; pre_t = 64'h300;
    tick();
    res_v = 1'b0; res_m = 1'b0; pre_v = 1'b0; pre_tk = 1'b0;
    sample();
    n_run++; if (addr !== 64'h200) begin n_fail++; $display("FAIL prio_res_addr got=%h exp=200", addr); end
    pre_v = 1'b1; pre_tk = 1'b1; pre_t = 64'h3F7;
    tick();
    pre_v = 1'b0; pre_tk = 1'b0;
    sample();
    n_run++; if (addr !== 64'h3F0) begin n_fail++; $display("FAIL prio_pre_addr got=%h exp=3f0", addr); end
    tick();
  endtask

  task automatic test_redirect_accept;
    ready = 1'b1;
    pre_v = 1'b1; pre_tk = 1'b1; pre_t = 64'h500;
    sample();
    n_run++; if (addr !== 64'h3F0) begin n_fail++; $display("FAIL ra_addr got=%h exp=3f0", addr); end
    tick();
    pre_v = 1'b0; pre_tk = 1'b0;
    ready = 1'b0;
    data_valid = 1'b1;
    sample();
    n_run++; if (addr !== 64'h500) begin n_fail++; $display("FAIL ra_next_addr got=%h exp=500", addr); end
    n_run++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL ra_outstanding got=%0d exp=1", outstanding); end
    n_run++; if (resp_pc !== 64'h3F0) begin n_fail++; $display("FAIL ra_resp_pc got=%h exp=3f0", resp_pc); end
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL ra_stale got=%0b exp=0", resp_valid); end
    tick();
    sample();
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL empty_resp got=%0b exp=0", resp_valid); end
    n_run++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL empty_outstanding got=%0d exp=0", outstanding); end
    tick();
    data_valid = 1'b0;
    sample();
    n_run++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL underflow got=%0d exp=0", outstanding); end
    tick();
  endtask

  task automatic test_reset_midflight;
    ready = 1'b1;
    tick();
    tick();
    sample();
    n_run++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL mid_pre_outstanding got=%0d exp=2", outstanding); end
    reset = 1'b0;
    #1;
    n_run++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL mid_outstanding got=%0d exp=0", outstanding); end
    n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%0b exp=0", addr_valid); end
    n_run++; if (addr !== 64'h0) begin n_fail++; $display("FAIL mid_addr got=%h exp=0", addr); end
    tick();
    reset = 1'b1;
    sample();
    n_run++; if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_boot_valid got=%0b exp=0", addr_valid); end
    tick();
    sample();
    n_run++; if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_restart_valid got=%0b exp=1", addr_valid); end
    n_run++; if (addr !== 64'h8000_0000) begin n_fail++; $display("FAIL mid_restart_addr got=%h exp=80000000", addr); end
    n_run++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL mid_restart_outstanding got=%0d exp=0", outstanding); end
    tick();
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_back_to_back();
    test_hold();
    test_mispredict();
    test_priority();
    test_redirect_accept();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
